// File: rtl/xbus_ctrl.sv
// xbus_ctrl: two-port arbiter and phase sequencer for the 8-bit muxed bus.
// Optional high-address latch cache enabled by defining XBUS_HICACHE_EN.
module xbus_ctrl #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_word,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_word,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic [7:0]  bus_out,
  input  logic [7:0]  bus_in,
  output logic        bus_ind,
  output logic        bus_write,
  output logic        bus_latch_hi,
  output logic        bus_latch_lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_LHI, S_LLO, S_D0, S_D1, S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        word_q, word_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rlo_q, rlo_d;
  logic [15:0] p0_rdata_q, p0_rdata_d;
  logic [15:0] p1_rdata_q, p1_rdata_d;
  logic [7:0]  out_q, out_d;
  logic        ind_q, ind_d;
  logic        wr_q, wr_d;
  logic        lhi_q, lhi_d;
  logic        llo_q, llo_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
`ifdef XBUS_HICACHE_EN
  logic        hv_q, hv_d;
  logic [7:0]  hr_q, hr_d;
`endif

  logic        both;
  logic        pick;
  logic [15:0] sel_addr;
  logic        sel_word;
  logic [15:0] rd_val;

  assign both     = p0_req & p1_req;
  assign pick     = both ? (~last_q & ~FIXED_PRIO) : p1_req;
  assign sel_addr = pick ? p1_addr : p0_addr;
  assign sel_word = pick ? p1_word : p0_word;
  assign rd_val   = word_q ? {bus_in, rlo_q} : {8'h00, bus_in};

  // Arbitration, request capture, phase sequencing and read capture
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rlo_d      = rlo_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef XBUS_HICACHE_EN
    hv_d       = hv_q;
    hr_d       = hr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (p0_req | p1_req) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? p1_we : p0_we;
          word_d  = sel_word;
          wdata_d = pick ? p1_wdata : p0_wdata;
          addr_d  = {sel_addr[15:1], sel_addr[0] & ~sel_word};
          state_d = S_LHI;
`ifdef XBUS_HICACHE_EN
          if (hv_q && addr_d[15:8] == hr_q) begin
            state_d = S_LLO;
          end else begin
            hv_d = 1'b1;
            hr_d = addr_d[15:8];
          end
`endif
        end
      end
      S_LHI: state_d = S_LLO;
      S_LLO: state_d = S_D0;
      S_D0: begin
        rlo_d   = bus_in;
        state_d = word_q ? S_D1 : S_ACK;
        if (!word_q && !we_q) begin
          if (gnt_q) p1_rdata_d = rd_val;
          else       p0_rdata_d = rd_val;
        end
      end
      S_D1: begin
        state_d = S_ACK;
        if (!we_q) begin
          if (gnt_q) p1_rdata_d = rd_val;
          else       p0_rdata_d = rd_val;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins and acks for the state being entered, so they are registered
  always_comb begin
    out_d  = 8'h00;
    ind_d  = 1'b0;
    wr_d   = 1'b0;
    lhi_d  = 1'b0;
    llo_d  = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    case (state_d)
      S_LHI: begin
        out_d = addr_d[15:8];
        lhi_d = 1'b1;
      end
      S_LLO: begin
        out_d = {addr_d[7:1], 1'b0};
        llo_d = 1'b1;
      end
      S_D0: begin
        ind_d = ~word_d & addr_d[0];
        if (we_d) begin
          out_d = wdata_d[7:0];
          wr_d  = 1'b1;
        end
      end
      S_D1: begin
        ind_d = 1'b1;
        if (we_d) begin
          out_d = wdata_d[15:8];
          wr_d  = 1'b1;
        end
      end
      S_ACK: begin
        ack0_d = ~gnt_d;
        ack1_d = gnt_d;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rlo_q      <= 8'h00;
      p0_rdata_q <= 16'h0000;
      p1_rdata_q <= 16'h0000;
      out_q      <= 8'h00;
      ind_q      <= 1'b0;
      wr_q       <= 1'b0;
      lhi_q      <= 1'b0;
      llo_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
`ifdef XBUS_HICACHE_EN
      hv_q       <= 1'b0;
      hr_q       <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rlo_q      <= rlo_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      out_q      <= out_d;
      ind_q      <= ind_d;
      wr_q       <= wr_d;
      lhi_q      <= lhi_d;
      llo_q      <= llo_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
`ifdef XBUS_HICACHE_EN
      hv_q       <= hv_d;
      hr_q       <= hr_d;
`endif
    end
  end

  assign p0_ack       = ack0_q;
  assign p1_ack       = ack1_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign bus_out      = out_q;
  assign bus_ind      = ind_q;
  assign bus_write    = wr_q;
  assign bus_latch_hi = lhi_q;
  assign bus_latch_lo = llo_q;

endmodule

// File: tb/tb_xbus_ctrl.sv
// tb_xbus_ctrl: directed bench for xbus_ctrl with an external latch/memory model.
// Cache expectations follow XBUS_HICACHE_EN.
module tb_xbus_ctrl;

`ifdef XBUS_HICACHE_EN
  localparam int   HIT_LAT = 3;
  localparam logic HIT_HI  = 1'b0;
`else
  localparam int   HIT_LAT = 4;
  localparam logic HIT_HI  = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req = 0, p0_we = 0, p0_word = 0;
  logic [15:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_word = 0;
  logic [15:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [7:0]  bus_out, bus_in;
  logic        bus_ind, bus_write, bus_latch_hi, bus_latch_lo;

  logic        f0_ack, f1_ack, f_ind, f_wr, f_lhi, f_llo;
  logic [15:0] f0_rdata, f1_rdata;
  logic [7:0]  f_out;

  xbus_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_word(p0_word),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .bus_out(bus_out), .bus_in(bus_in), .bus_ind(bus_ind),
    .bus_write(bus_write), .bus_latch_hi(bus_latch_hi),
    .bus_latch_lo(bus_latch_lo)
  );

  xbus_ctrl #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_word(p0_word),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(f0_ack), .p0_rdata(f0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_word(p1_word),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(f1_ack), .p1_rdata(f1_rdata),
    .bus_out(f_out), .bus_in(8'h00), .bus_ind(f_ind),
    .bus_write(f_wr), .bus_latch_hi(f_lhi),
    .bus_latch_lo(f_llo)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  lat_hi = 8'h00;
  logic [6:0]  lat_lo = 7'h00;
  logic [15:0] maddr;
  logic        ld_en = 1'b0;
  logic [15:0] ld_a = 16'h0000;
  logic [7:0]  ld_d = 8'h00;

  assign maddr  = {lat_hi, lat_lo, bus_ind};
  assign bus_in = mem[maddr];

  always @(negedge clk) begin
    if (bus_latch_hi) lat_hi <= bus_out;
    if (bus_latch_lo) lat_lo <= bus_out[7:1];
  end

  always @(posedge clk) begin
    if (bus_write) mem[maddr] <= bus_out;
    if (ld_en) mem[ld_a] <= ld_d;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  t_out [16];
  logic        t_hi  [16];
  logic        t_lo  [16];
  logic        t_ind [16];
  logic        t_wr  [16];
  int          lat;
  logic        oth_any;
  logic [15:0] t_rd;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_a = a;
    ld_d = d;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  task automatic go(input logic port, input logic we, input logic word,
                    input logic [15:0] a, input logic [15:0] wd);
    if (port) begin
      p1_req = 1; p1_we = we; p1_word = word; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_req = 1; p0_we = we; p0_word = word; p0_addr = a; p0_wdata = wd;
    end
    lat = 0;
    oth_any = 1'b0;
    t_rd = 16'h0;
    for (int c = 1; c < 16; c++) begin
      step();
      t_out[c] = bus_out;
      t_hi[c]  = bus_latch_hi;
      t_lo[c]  = bus_latch_lo;
      t_ind[c] = bus_ind;
      t_wr[c]  = bus_write;
      oth_any  = oth_any | (port ? p0_ack : p1_ack);
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        t_rd = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 0;
    p1_req = 0;
    step();
  endtask

  int g [4];
  int n;
  int fp0, fp1;

  initial begin
    poke(16'h1235, 8'hA5);
    poke(16'h0400, 8'h11);
    poke(16'h0401, 8'h22);
    poke(16'h1210, 8'h5A);
    poke(16'h2000, 8'h00);
    poke(16'h2001, 8'h00);
    rst_n = 1'b1;

    chk("rst_out", 16'(bus_out), 16'h0);
    chk("rst_strb", 16'({bus_ind, bus_write, bus_latch_hi, bus_latch_lo}), 16'h0);
    chk("rst_ack", 16'({p0_ack, p1_ack}), 16'h0);
    chk("rst_rd0", p0_rdata, 16'h0000);
    chk("rst_rd1", p1_rdata, 16'h0000);

    go(1'b0, 1'b0, 1'b0, 16'h1235, 16'h0);
    chk("br_lat", 16'(lat), 16'd4);
    chk("br_hi1", 16'(t_hi[1]), 16'h1);
    chk("br_out1", 16'(t_out[1]), 16'h12);
    chk("br_lo2", 16'(t_lo[2]), 16'h1);
    chk("br_out2", 16'(t_out[2]), 16'h34);
    chk("br_ind3", 16'(t_ind[3]), 16'h1);
    chk("br_wr3", 16'(t_wr[3]), 16'h0);
    chk("br_data", t_rd, 16'h00A5);
    chk("br_p1ack", 16'(oth_any), 16'h0);

    go(1'b1, 1'b1, 1'b1, 16'h2001, 16'hBEEF);
    chk("ww_lat", 16'(lat), 16'd5);
    chk("ww_out1", 16'(t_out[1]), 16'h20);
    chk("ww_out2", 16'(t_out[2]), 16'h00);
    chk("ww_out3", 16'(t_out[3]), 16'hEF);
    chk("ww_ind3", 16'(t_ind[3]), 16'h0);
    chk("ww_wr3", 16'(t_wr[3]), 16'h1);
    chk("ww_out4", 16'(t_out[4]), 16'hBE);
    chk("ww_ind4", 16'(t_ind[4]), 16'h1);
    chk("ww_wr4", 16'(t_wr[4]), 16'h1);
    chk("ww_mem0", 16'(mem[16'h2000]), 16'hEF);
    chk("ww_mem1", 16'(mem[16'h2001]), 16'hBE);
    chk("ww_p0ack", 16'(oth_any), 16'h0);
    chk("ww_p0rd", p0_rdata, 16'h00A5);

    go(1'b0, 1'b0, 1'b1, 16'h0400, 16'h0);
    chk("wr_lat", 16'(lat), 16'd5);
    chk("wr_data", t_rd, 16'h2211);
    step();
    step();
    chk("wr_hold", p0_rdata, 16'h2211);
    chk("wr_p1rd", p1_rdata, 16'h0000);

    p0_req = 1; p0_we = 1; p0_word = 1;
    p0_addr = 16'h3000; p0_wdata = 16'h1234;
    step();
    step();
    step();
    chk("mr_d0wr", 16'(bus_write), 16'h1);
    rst_n = 1'b0;
    p0_req = 0;
    step();
    chk("mr_strb", 16'({bus_ind, bus_write, bus_latch_hi, bus_latch_lo}), 16'h0);
    chk("mr_out", 16'(bus_out), 16'h0);
    chk("mr_ack", 16'({p0_ack, p1_ack}), 16'h0);
    chk("mr_rd0", p0_rdata, 16'h0000);
    rst_n = 1'b1;

    p0_req = 1; p0_we = 0; p0_word = 0; p0_addr = 16'h3002;
    p1_req = 1; p1_we = 0; p1_word = 0; p1_addr = 16'h3003;
    n = 0;
    fp0 = 0;
    fp1 = 0;
    for (int c = 1; c < 60 && n < 4; c++) begin
      step();
      if (c == 1) begin
        chk("ar_lhi", 16'(bus_latch_hi), 16'h1);
        chk("ar_out1", 16'(bus_out), 16'h30);
      end
      if (f0_ack) fp0++;
      if (f1_ack) fp1++;
      if (p0_ack) begin g[n] = 0; n++; end
      else if (p1_ack) begin g[n] = 1; n++; end
    end
    p0_req = 0;
    p1_req = 0;
    step();
    chk("ar_n", 16'(n), 16'd4);
    chk("ar_g0", 16'(g[0]), 16'd0);
    chk("ar_g1", 16'(g[1]), 16'd1);
    chk("ar_g2", 16'(g[2]), 16'd0);
    chk("ar_g3", 16'(g[3]), 16'd1);
    chk("fp_p0", 16'(fp0), 16'd4);
    chk("fp_p1", 16'(fp1), 16'd0);

    go(1'b0, 1'b0, 1'b0, 16'h1200, 16'h0);
    chk("hc_lat0", 16'(lat), 16'd4);
    chk("hc_hi0", 16'(t_hi[1]), 16'h1);
    go(1'b0, 1'b0, 1'b0, 16'h1210, 16'h0);
    chk("hc_lat1", 16'(lat), 16'(HIT_LAT));
    chk("hc_hi1", 16'(t_hi[1]), 16'(HIT_HI));
    chk("hc_data", t_rd, 16'h005A);
    go(1'b0, 1'b0, 1'b0, 16'h1300, 16'h0);
    chk("hc_lat2", 16'(lat), 16'd4);
    chk("hc_hi2", 16'(t_hi[1]), 16'h1);
    chk("hc_out2", 16'(t_out[1]), 16'h13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
